oq_regs_update_seq: RTL

- Initiator side of the output-queue full-evaluation interface.
- Accepts store (enqueue) and remove (dequeue) events from the OQ write and read paths, and keeps per-queue packet counts and words-left in internal register arrays.
- Drives the dst (store) and src (remove) update/done strobe sequences that the full evaluator consumes, honouring its one-cycle read latency.
- Sits between the OQ SRAM controllers and the full/empty evaluation logic in the user datapath.

---
 rtl/oq_regs_update_seq.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/oq_regs_update_seq.sv
// Output-queue update sequencer: store/remove pipelines feeding the full evaluator.
// Optional OQ_UPDATE_STATS_EN adds stat_stores/stat_removes request counters.
module oq_regs_update_seq #(
   parameter int NUM_OUTPUT_QUEUES = 8,
   parameter int NUM_OQ_WIDTH      = 3,
   parameter int SRAM_ADDR_WIDTH   = 13,
   parameter int PKT_WORDS_WIDTH   = 8,
   parameter int PKTS_IN_RAM_WIDTH = 10
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         store_req,
   input  logic [NUM_OQ_WIDTH-1:0]      store_oq,
   input  logic [PKT_WORDS_WIDTH-1:0]   store_words,
   input  logic                         remove_req,
   input  logic [NUM_OQ_WIDTH-1:0]      remove_oq,
   input  logic [PKT_WORDS_WIDTH-1:0]   remove_words,
   input  logic                         cfg_wr,
   input  logic [NUM_OQ_WIDTH-1:0]      cfg_oq,
   input  logic [PKTS_IN_RAM_WIDTH-1:0] cfg_max_pkts,
   input  logic [SRAM_ADDR_WIDTH-1:0]   cfg_full_thresh,
   input  logic [SRAM_ADDR_WIDTH-1:0]   cfg_size,
`ifdef OQ_UPDATE_STATS_EN
   output logic [31:0]                  stat_stores,
   output logic [31:0]                  stat_removes,
`endif
   output logic                         initialize,
   output logic [NUM_OQ_WIDTH-1:0]      initialize_oq,
   output logic                         dst_update,
   output logic [NUM_OQ_WIDTH-1:0]      dst_oq,
   output logic [PKTS_IN_RAM_WIDTH-1:0] dst_max_pkts_in_q,
   output logic [SRAM_ADDR_WIDTH-1:0]   dst_oq_full_thresh,
   output logic [PKTS_IN_RAM_WIDTH-1:0] dst_num_pkts_in_q,
   output logic                         dst_num_pkts_in_q_done,
   output logic [SRAM_ADDR_WIDTH-1:0]   dst_num_words_left,
   output logic                         dst_num_words_left_done,
   output logic                         src_update,
   output logic [NUM_OQ_WIDTH-1:0]      src_oq,
   output logic [PKTS_IN_RAM_WIDTH-1:0] src_max_pkts_in_q,
   output logic [SRAM_ADDR_WIDTH-1:0]   src_oq_full_thresh,
   output logic [PKTS_IN_RAM_WIDTH-1:0] src_num_pkts_in_q,
   output logic                         src_num_pkts_in_q_done,
   output logic [SRAM_ADDR_WIDTH-1:0]   src_num_words_left,
   output logic                         src_num_words_left_done,
   output logic                         err_underflow,
   output logic                         err_overflow
);

   localparam int NQ  = NUM_OUTPUT_QUEUES;
   localparam int QW  = NUM_OQ_WIDTH;
   localparam int AW  = SRAM_ADDR_WIDTH;
   localparam int AW1 = SRAM_ADDR_WIDTH + 1;
   localparam int WW  = PKT_WORDS_WIDTH;
   localparam int PW  = PKTS_IN_RAM_WIDTH;

   logic          dv0_q, dv1_q, sv0_q, sv1_q;
   logic [QW-1:0] doq0_q, doq1_q, soq0_q, soq1_q;
   logic [WW-1:0] dw0_q, dw1_q, sw0_q, sw1_q;

   logic [PW-1:0] pkts_q [NQ];
   logic [AW-1:0] wl_q   [NQ];
   logic [PW-1:0] max_q  [NQ];
   logic [AW-1:0] thr_q  [NQ];
   logic [AW-1:0] size_q [NQ];

   logic [PW-1:0] dmax_q, smax_q, dnum_q, snum_q;
   logic [AW-1:0] dthr_q, sthr_q, dwl_q, swl_q;
   logic          ddone_q, sdone_q, unf_q, ovf_q;
   logic          init_q;
   logic [QW-1:0] init_oq_q;
   logic [NQ-1:0] pend_q;

   logic [PW-1:0] d_pk, d_pk_d, s_pk, s_pk_d;
   logic [AW-1:0] d_wl, d_wl_d, d_wx, s_wl, s_wl_d, s_sz;
   logic [AW:0]   s_sum;
   logic          d_ovf, d_unf, s_ovf, s_unf, same;

   // C1 arithmetic; a same-queue remove builds on the store result
   always_comb begin
      d_pk   = pkts_q[doq1_q];
      d_wl   = wl_q[doq1_q];
      d_wx   = AW'(dw1_q);
      d_ovf  = (d_pk == '1);
      d_pk_d = d_ovf ? d_pk : d_pk + PW'(1);
      d_unf  = (d_wx > d_wl);
      d_wl_d = d_unf ? '0 : d_wl - d_wx;
      same   = dv1_q && (doq1_q == soq1_q);
      s_pk   = same ? d_pk_d : pkts_q[soq1_q];
      s_wl   = same ? d_wl_d : wl_q[soq1_q];
      s_sz   = size_q[soq1_q];
      s_unf  = (s_pk == '0);
      s_pk_d = s_unf ? s_pk : s_pk - PW'(1);
      s_sum  = {1'b0, s_wl} + AW1'(sw1_q);
      s_ovf  = (s_sum > {1'b0, s_sz});
      s_wl_d = s_ovf ? s_sz : s_sum[AW-1:0];
   end

   logic [NQ-1:0] pend_all, pend_d;
   logic          ini_v;
   logic [QW-1:0] ini_oq;

   // pick a pending init whose queue has no done strobe next cycle
   always_comb begin
      pend_all = pend_q;
      if (cfg_wr) pend_all[cfg_oq] = 1'b1;
      ini_v  = 1'b0;
      ini_oq = '0;
      for (int i = NQ - 1; i >= 0; i--) begin
         if (pend_all[i] &&
             !(dv1_q && doq1_q == QW'(i)) &&
             !(sv1_q && soq1_q == QW'(i))) begin
            ini_v  = 1'b1;
            ini_oq = QW'(i);
         end
      end
      pend_d = pend_all;
      if (ini_v) pend_d[ini_oq] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         {dv0_q, dv1_q, sv0_q, sv1_q} <= '0;
         {doq0_q, doq1_q, soq0_q, soq1_q} <= '0;
         {dw0_q, dw1_q, sw0_q, sw1_q} <= '0;
         for (int i = 0; i < NQ; i++) begin
            pkts_q[i] <= '0;
            wl_q[i]   <= '0;
            max_q[i]  <= '0;
            thr_q[i]  <= '0;
            size_q[i] <= '0;
         end
         {dmax_q, smax_q, dnum_q, snum_q} <= '0;
         {dthr_q, sthr_q, dwl_q, swl_q} <= '0;
         {ddone_q, sdone_q, unf_q, ovf_q} <= '0;
         init_q    <= 1'b0;
         init_oq_q <= '0;
         pend_q    <= '0;
      end else begin
         dv0_q  <= store_req;
         doq0_q <= store_oq;
         dw0_q  <= store_words;
         sv0_q  <= remove_req;
         soq0_q <= remove_oq;
         sw0_q  <= remove_words;
         dv1_q  <= dv0_q;
         doq1_q <= doq0_q;
         dw1_q  <= dw0_q;
         sv1_q  <= sv0_q;
         soq1_q <= soq0_q;
         sw1_q  <= sw0_q;
         if (dv0_q) begin
            dmax_q <= max_q[doq0_q];
            dthr_q <= thr_q[doq0_q];
         end
         if (sv0_q) begin
            smax_q <= max_q[soq0_q];
            sthr_q <= thr_q[soq0_q];
         end
         ddone_q <= dv1_q;
         sdone_q <= sv1_q;
         if (dv1_q) begin
            dnum_q         <= d_pk_d;
            dwl_q          <= d_wl_d;
            pkts_q[doq1_q] <= d_pk_d;
            wl_q[doq1_q]   <= d_wl_d;
         end
         if (sv1_q) begin
            snum_q         <= s_pk_d;
            swl_q          <= s_wl_d;
            pkts_q[soq1_q] <= s_pk_d;
            wl_q[soq1_q]   <= s_wl_d;
         end
         if ((dv1_q && (d_unf || (sv1_q && same && s_unf))) ||
             (sv1_q && s_unf)) unf_q <= 1'b1;
         if ((dv1_q && d_ovf) || (sv1_q && s_ovf)) ovf_q <= 1'b1;
         if (cfg_wr) begin
            max_q[cfg_oq]  <= cfg_max_pkts;
            thr_q[cfg_oq]  <= cfg_full_thresh;
            size_q[cfg_oq] <= cfg_size;
            wl_q[cfg_oq]   <= cfg_size;
            pkts_q[cfg_oq] <= '0;
         end
         init_q    <= ini_v;
         init_oq_q <= ini_oq;
         pend_q    <= pend_d;
      end
   end

`ifdef OQ_UPDATE_STATS_EN
   logic [31:0] st_q, rm_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st_q <= '0;
         rm_q <= '0;
      end else begin
         if (store_req)  st_q <= st_q + 32'd1;
         if (remove_req) rm_q <= rm_q + 32'd1;
      end
   end
   assign stat_stores  = st_q;
   assign stat_removes = rm_q;
`endif

   assign initialize              = init_q;
   assign initialize_oq           = init_oq_q;
   assign dst_update              = dv0_q;
   assign dst_oq                  = doq0_q;
   assign dst_max_pkts_in_q       = dmax_q;
   assign dst_oq_full_thresh      = dthr_q;
   assign dst_num_pkts_in_q       = dnum_q;
   assign dst_num_pkts_in_q_done  = ddone_q;
   assign dst_num_words_left      = dwl_q;
   assign dst_num_words_left_done = ddone_q;
   assign src_update              = sv0_q;
   assign src_oq                  = soq0_q;
   assign src_max_pkts_in_q       = smax_q;
   assign src_oq_full_thresh      = sthr_q;
   assign src_num_pkts_in_q       = snum_q;
   assign src_num_pkts_in_q_done  = sdone_q;
   assign src_num_words_left      = swl_q;
   assign src_num_words_left_done = sdone_q;
   assign err_underflow           = unf_q;
   assign err_overflow            = ovf_q;

endmodule
